if_id_buf: RTL and testbench
============================

IF_ID_BUF -- requirements
Module: if_id_buf

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 32, meaning PC width.
REQ-002 The module SHALL have parameter INST_W, default 32, meaning instruction width.
REQ-003 The module SHALL have parameter DEPTH, default 4, meaning queue entries; legal values are powers of two >= 2.
REQ-004 The module SHALL have parameter STALL_W, default 6, meaning stall vector width; bit 1 = IF, bit 2 = ID.
REQ-005 The module SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 The module SHALL have port rst, input, 1 bit: one clock; reset is asynchronous and active-low.
REQ-007 The module SHALL have port stall, input, STALL_W bits: pipeline stall vector, 1 = Stop.
REQ-008 The module SHALL have port flush, input, 1 bit: discard all buffered and ID-held instructions.
REQ-009 The module SHALL have port if_valid, input, 1 bit: fetch slot carries a valid instruction.
REQ-010 The module SHALL have port if_pc, input, ADDR_W bits: fetched PC.
REQ-011 The module SHALL have port if_inst, input, INST_W bits: fetched instruction.
REQ-012 The module SHALL have port if_ready, output, 1 bit: queue can accept a push this cycle.
REQ-013 The module SHALL have port id_valid, output, 1 bit (registered): ID slot holds a real instruction.
REQ-014 The module SHALL have port id_pc, output, ADDR_W bits (registered): PC presented to decode.
REQ-015 The module SHALL have port id_inst, output, INST_W bits (registered): instruction presented to decode.
REQ-016 The module SHALL have port count, output, $clog2(DEPTH)+1 bits: occupied queue entries, excluding the ID slot.

Function
REQ-017 if_ready SHALL equal (count < DEPTH); it is combinational from state only.
REQ-018 push SHALL occur when if_valid=1, if_ready=1, stall[1]=0 and flush=0.
REQ-019 The ID slot SHALL advance on a rising edge when stall[2]=0 and flush=0; it SHALL hold all id_* outputs when stall[2]=1.
REQ-020 On advance with count>0, the ID slot SHALL load the head entry (pop) with id_valid=1.
REQ-021 On advance with count=0 and push active, the ID slot SHALL load if_pc/if_inst directly with id_valid=1 (bypass), the queue SHALL be left unchanged, and the latency SHALL be 1 cycle.
REQ-022 On advance with count=0 and no push, the ID slot SHALL load a bubble: id_pc=0, id_inst=0, id_valid=0.
REQ-023 Simultaneous push and pop (count>0) SHALL keep count unchanged and write at the tail, with FIFO order preserved.
REQ-024 When full, push SHALL be blocked even if a pop occurs the same cycle.
REQ-025 Read and write pointers SHALL be $clog2(DEPTH) bits and SHALL wrap modulo DEPTH; count tracks occupancy.
REQ-026 Flush SHALL take priority over stall and push: next edge count=0, pointers=0, id_pc=0, id_inst=0, id_valid=0; the fetch presented in the flush cycle SHALL be dropped.
REQ-027 When stall[2]=1 and the queue is not full, pushes SHALL continue to fill the queue.
REQ-028 count SHALL never exceed DEPTH nor underflow below 0.

Reset
REQ-029 rst=0 SHALL immediately, without waiting for clk, force id_pc=0, id_inst=all ones (debug marker), id_valid=0, count=0, and both pointers=0.
REQ-030 Queue storage contents SHALL need no reset.
REQ-031 After rst deasserts, the first rising edge SHALL behave per REQ-017..REQ-028 (if_ready=1).
REQ-032 Assertion of rst mid-operation SHALL discard all entries with no partial pop or push.

Verification
REQ-033 Bench SHALL drive reset, then if_valid=1 with pc=0x100, inst=0x24010001 and stall=0 -> the next edge gives id_pc=0x100, id_valid=1, count=0 (bypass).
REQ-034 Bench SHALL hold stall[2]=1 and push 4 entries pc=0x0,0x4,0x8,0xC -> count=4, if_ready=0, and a 5th push is ignored; after release, IDs present 0x0,0x4,0x8,0xC on successive edges.
REQ-035 Bench SHALL keep count=2 and push while stall=0 -> count stays 2 and order is preserved across pointer wrap for more than 8 transactions.
REQ-036 Bench SHALL assert flush with count=3, stall[2]=1 and if_valid=1 -> the next edge gives count=0, id_valid=0, id_inst=0, and the dropped fetch never appears.
REQ-037 Bench SHALL set stall[1]=1, stall[2]=0 with an empty queue -> a bubble is produced (id_pc=0, id_inst=0, id_valid=0) and if_valid is ignored.
REQ-038 Bench SHALL assert rst=0 asynchronously between edges with count=2 -> outputs change immediately to id_inst=0xFFFFFFFF, id_valid=0, count=0.

Source files
------------

// File: rtl/if_id_buf.sv
// IF->ID decoupling queue feeding a registered decode slot.
// An empty queue lets a fetch go straight into ID; flush empties both queue and slot.
module if_id_buf #(
    parameter int ADDR_W  = 32,
    parameter int INST_W  = 32,
    parameter int DEPTH   = 4,
    parameter int STALL_W = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [STALL_W-1:0]       stall,
    input  logic                     flush,
    input  logic                     if_valid,
    input  logic [ADDR_W-1:0]        if_pc,
    input  logic [INST_W-1:0]        if_inst,
    output logic                     if_ready,
    output logic                     id_valid,
    output logic [ADDR_W-1:0]        id_pc,
    output logic [INST_W-1:0]        id_inst,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              id_valid_q, id_valid_d;
    logic [ADDR_W-1:0] id_pc_q, id_pc_d;
    logic [INST_W-1:0] id_inst_q, id_inst_d;

    logic push, advance, pop, bypass, wr_en;
    logic stall_unused;

    assign stall_unused = ^stall;

    assign if_ready = (count_q < CNT_W'(DEPTH));
    assign push     = if_valid && if_ready && !stall[1] && !flush;
    assign advance  = !stall[2] && !flush;
    assign pop      = advance && (count_q != '0);
    // A fetch that bypasses into ID never occupies a queue entry.
    assign bypass   = advance && (count_q == '0) && push;
    assign wr_en    = push && !bypass;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc_mem[wr_ptr_q]   <= if_pc;
            inst_mem[wr_ptr_q] <= if_inst;
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        id_valid_d = id_valid_q;
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            id_valid_d = 1'b0;
            id_pc_d    = '0;
            id_inst_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (wr_en && !pop)      count_d = count_q + CNT_W'(1);
            else if (!wr_en && pop) count_d = count_q - CNT_W'(1);
            if (advance) begin
                if (pop) begin
                    id_valid_d = 1'b1;
                    id_pc_d    = pc_mem[rd_ptr_q];
                    id_inst_d  = inst_mem[rd_ptr_q];
                end else if (push) begin
                    id_valid_d = 1'b1;
                    id_pc_d    = if_pc;
                    id_inst_d  = if_inst;
                end else begin
                    id_valid_d = 1'b0;
                    id_pc_d    = '0;
                    id_inst_d  = '0;
                end
            end
        end
    end

    // All-ones instruction after reset marks "never loaded" for debug.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            id_valid_q <= 1'b0;
            id_pc_q    <= '0;
            id_inst_q  <= '1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
        end
    end

    assign id_valid = id_valid_q;
    assign id_pc    = id_pc_q;
    assign id_inst  = id_inst_q;
    assign count    = count_q;

endmodule

// File: tb/tb_if_id_buf.sv
// Bench for if_id_buf: vector table, directed corner sequences, and random
// traffic compared against a queue-based reference model.
module tb_if_id_buf;

    localparam int DEPTH = 4;
    localparam logic [5:0] ST1 = 6'b000010;
    localparam logic [5:0] ST2 = 6'b000100;

    logic        clk, rst, flush, if_valid, if_ready, id_valid;
    logic [5:0]  stall;
    logic [31:0] if_pc, if_inst, id_pc, id_inst;
    logic [2:0]  count;

    int tests = 0;
    int fails = 0;

    if_id_buf #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH), .STALL_W(6)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
        .if_ready(if_ready), .id_valid(id_valid), .id_pc(id_pc),
        .id_inst(id_inst), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a plain queue of fetched entries plus the decode slot.
    logic [31:0] q_pc[$];
    logic [31:0] q_inst[$];
    logic        m_valid;
    logic [31:0] m_pc, m_inst;

    function automatic void model_reset();
        q_pc.delete();
        q_inst.delete();
        m_valid = 1'b0;
        m_pc    = '0;
        m_inst  = '1;
    endfunction

    function automatic void model_edge(input logic [5:0] st, input logic fl,
                                       input logic v, input logic [31:0] pc,
                                       input logic [31:0] inst);
        logic ready, psh, took;
        ready = (q_pc.size() < DEPTH);
        psh   = v && ready && !st[1] && !fl;
        took  = 1'b0;
        if (fl) begin
            q_pc.delete();
            q_inst.delete();
            m_valid = 1'b0; m_pc = '0; m_inst = '0;
        end else begin
            if (!st[2]) begin
                if (q_pc.size() > 0) begin
                    m_valid = 1'b1;
                    m_pc    = q_pc.pop_front();
                    m_inst  = q_inst.pop_front();
                end else if (psh) begin
                    m_valid = 1'b1; m_pc = pc; m_inst = inst;
                    took = 1'b1;
                end else begin
                    m_valid = 1'b0; m_pc = '0; m_inst = '0;
                end
            end
            if (psh && !took) begin
                q_pc.push_back(pc);
                q_inst.push_back(inst);
            end
        end
    endfunction

    function automatic logic [68:0] dut_vec();
        return {id_valid, id_pc, id_inst, count, if_ready};
    endfunction

    function automatic logic [68:0] model_vec();
        return {m_valid, m_pc, m_inst, 3'(q_pc.size()), (q_pc.size() < DEPTH)};
    endfunction

    function automatic logic [31:0] io(input logic [31:0] pc);
        return pc ^ 32'h5A000013;
    endfunction

    task automatic chk(input string name, input logic [68:0] got, input logic [68:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got v=%0b pc=%h inst=%h cnt=%0d rdy=%0b, want v=%0b pc=%h inst=%h cnt=%0d rdy=%0b",
                     name, got[68], got[67:36], got[35:4], got[3:1], got[0],
                     exp[68], exp[67:36], exp[35:4], exp[3:1], exp[0]);
        end
    endtask

    task automatic step(input logic [5:0] st, input logic fl, input logic v,
                        input logic [31:0] pc, input logic [31:0] inst);
        stall = st; flush = fl; if_valid = v; if_pc = pc; if_inst = inst;
        model_edge(st, fl, v, pc, inst);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string       name;
        logic [5:0]  st;
        logic        fl;
        logic        v;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [68:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input string name, input logic [5:0] st, input logic v,
                                input logic [31:0] pc, input logic ev,
                                input logic [31:0] epc, input logic [31:0] einst,
                                input logic [2:0] ecnt, input logic erdy);
        vec_t r;
        r.name = name; r.st = st; r.fl = 1'b0; r.v = v; r.pc = pc;
        r.inst = (pc == 32'h100) ? 32'h24010001 : io(pc);
        r.exp  = {ev, epc, einst, ecnt, erdy};
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] rs;
        rst = 1'b1; stall = '0; flush = 1'b0; if_valid = 1'b0; if_pc = '0; if_inst = '0;
        model_reset();
        #1 rst = 1'b0;
        #1 chk("reset", dut_vec(), {1'b0, 32'h0, 32'hFFFFFFFF, 3'd0, 1'b1});
        #4 rst = 1'b1;

        tbl.push_back(mk("bypass",     6'b0, 1, 32'h100, 1, 32'h100, 32'h24010001, 0, 1));
        tbl.push_back(mk("fill0",      ST2,  1, 32'h0,   1, 32'h100, 32'h24010001, 1, 1));
        tbl.push_back(mk("fill4",      ST2,  1, 32'h4,   1, 32'h100, 32'h24010001, 2, 1));
        tbl.push_back(mk("fill8",      ST2,  1, 32'h8,   1, 32'h100, 32'h24010001, 3, 1));
        tbl.push_back(mk("fillC",      ST2,  1, 32'hC,   1, 32'h100, 32'h24010001, 4, 0));
        tbl.push_back(mk("fifth",      ST2,  1, 32'h10,  1, 32'h100, 32'h24010001, 4, 0));
        tbl.push_back(mk("full_pop",   6'b0, 1, 32'h20,  1, 32'h0,   io(32'h0),    3, 1));
        tbl.push_back(mk("drain4",     6'b0, 0, 32'h0,   1, 32'h4,   io(32'h4),    2, 1));
        tbl.push_back(mk("drain8",     6'b0, 0, 32'h0,   1, 32'h8,   io(32'h8),    1, 1));
        tbl.push_back(mk("drainC",     6'b0, 0, 32'h0,   1, 32'hC,   io(32'hC),    0, 1));
        tbl.push_back(mk("bubble",     6'b0, 0, 32'h0,   0, 32'h0,   32'h0,        0, 1));
        tbl.push_back(mk("st1_bubble", ST1,  1, 32'h30,  0, 32'h0,   32'h0,        0, 1));
        tbl.push_back(mk("st1_again",  ST1,  1, 32'h34,  0, 32'h0,   32'h0,        0, 1));

        foreach (tbl[i]) begin
            step(tbl[i].st, tbl[i].fl, tbl[i].v, tbl[i].pc, tbl[i].inst);
            chk(tbl[i].name, dut_vec(), tbl[i].exp);
        end

        // Steady occupancy of two while streaming through pointer wrap.
        step(ST2, 0, 1, 32'h200, io(32'h200));
        step(ST2, 0, 1, 32'h204, io(32'h204));
        chk("prefill2", dut_vec(), model_vec());
        for (int i = 0; i < 12; i++) begin
            step(6'b0, 0, 1, 32'h208 + 32'(4 * i), io(32'h208 + 32'(4 * i)));
            chk("wrap", dut_vec(), {1'b1, 32'h200 + 32'(4 * i), io(32'h200 + 32'(4 * i)), 3'd2, 1'b1});
        end

        // Flush with three queued, ID stalled and a fetch arriving.
        step(ST2, 0, 1, 32'h300, io(32'h300));
        chk("pre_flush3", dut_vec(), model_vec());
        step(ST2, 1, 1, 32'hDEAD0, io(32'hDEAD0));
        chk("flush", dut_vec(), {1'b0, 32'h0, 32'h0, 3'd0, 1'b1});
        for (int i = 0; i < 3; i++) begin
            step(6'b0, 0, 0, 32'h0, 32'h0);
            chk("post_flush", dut_vec(), {1'b0, 32'h0, 32'h0, 3'd0, 1'b1});
        end

        // Asynchronous reset between edges with two queued.
        step(ST2, 0, 1, 32'h400, io(32'h400));
        step(ST2, 0, 1, 32'h404, io(32'h404));
        chk("pre_rst2", dut_vec(), model_vec());
        #2 rst = 1'b0;
        #1 chk("async_rst", dut_vec(), {1'b0, 32'h0, 32'hFFFFFFFF, 3'd0, 1'b1});
        model_reset();
        #2 rst = 1'b1;
        step(6'b0, 0, 0, 32'h0, 32'h0);
        chk("rst_bubble", dut_vec(), model_vec());
        step(ST2, 0, 1, 32'h500, io(32'h500));
        step(6'b0, 0, 0, 32'h0, 32'h0);
        chk("rst_fresh", dut_vec(), {1'b1, 32'h500, io(32'h500), 3'd0, 1'b1});

        for (int i = 0; i < 400; i++) begin
            rs = 6'($urandom);
            rs[1] = ($urandom_range(0, 3) == 0);
            rs[2] = ($urandom_range(0, 2) == 0);
            step(rs, ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                 $urandom, $urandom);
            chk("rand", dut_vec(), model_vec());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
